pipe_ctrl_gen: RTL
==================

Name: pipe_ctrl_gen

Overview:
Parametrised pipeline control unit for the MIPS core. It generalises stall generation to any number of stages and prioritises exceptions over stalls. It registers the flush/redirect to the PC stage and holds it for a configurable number of cycles. It also adds a stall watchdog that forces recovery from a hung stall, and a saturating stall-cycle performance counter.

Parameters:
STAGES, 6, width of stall vector; bit 0 = PC, bit i = stage i
FLUSH_CYCLES, 1, cycles flush/new_pc held after a redirect (>=1)
INT_VEC, 32'h0000_0020, interrupt handler address
EXC_VEC, 32'h0000_0040, general exception handler address
WD_VEC, 32'h0000_0080, watchdog recovery address
WD_LIMIT, 255, consecutive stall cycles before watchdog trip; 0 disables
WD_W, 8, watchdog counter width (2^WD_W > WD_LIMIT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
stallreq_i  in  STAGES  bit i: stage i requests stall
cp0_epc_i  in  32  EPC from CP0
excepttype_i  in  32  exception code from MEM stage, 0 = none
stall  out  STAGES  per-stage stall, combinational
new_pc  out  32  redirect target, registered
flush  out  1  pipeline flush, registered
wd_timeout  out  1  one-cycle pulse on watchdog trip, registered
stall_cnt_o  out  32  saturating count of cycles with stall != 0

Behaviour:
- Reset (async, rst=1): state RUN; flush=0, new_pc=0, wd_timeout=0, wd_cnt=0, flush_cnt=0, stall_cnt_o=0; stall forced to 0 while rst=1.
- FSM states are RUN and FLUSH.
- Stall (combinational, RUN only, excepttype_i==0):
  - k = highest index with stallreq_i[k]=1.
  - stall[j]=1 for all j<=k; all other bits 0.
  - No request gives stall=0.
- Stall in FLUSH or with excepttype_i!=0: stall=0, i.e. exception has priority.
- Exception decode in RUN with excepttype_i!=0; target is registered on the next edge:
  - 0x01 gives INT_VEC.
  - 0x08, 0x0a, 0x0c, 0x0d give EXC_VEC.
  - 0x0e gives cp0_epc_i, sampled in the detect cycle.
  - Any other nonzero code gives EXC_VEC.
- Redirect timing:
  - Detect in cycle t. Next edge: state=FLUSH, flush=1, new_pc=target, flush_cnt=FLUSH_CYCLES-1.
  - In FLUSH: excepttype_i and stallreq_i are ignored. flush and new_pc are held.
  - flush_cnt decrements each cycle. When flush_cnt==0, the next edge returns to RUN with flush=0 and new_pc=0.
  - Flush therefore stays high for exactly FLUSH_CYCLES cycles.
- Watchdog (WD_LIMIT>0):
  - In RUN, wd_cnt increments on each edge where stall!=0.
  - wd_cnt clears on any cycle with stall==0, and on entry to FLUSH.
  - Trip condition: stall!=0 and wd_cnt==WD_LIMIT-1, i.e. the WD_LIMIT-th consecutive stalled cycle.
  - On trip, the next edge enters FLUSH with new_pc=WD_VEC and wd_timeout=1 for one cycle only.
  - An exception in the same cycle cannot coincide with a trip, because it forces stall=0.
  - WD_LIMIT=0: no trip; wd_cnt held 0.
- stall_cnt_o: increments on each edge where stall!=0. Saturates at 32'hFFFF_FFFF with no wrap. Cleared only by rst.
- Reset mid-FLUSH aborts immediately: flush=0 and new_pc=0 asynchronously.

Test Plan:
- Reset: assert rst with random inputs -> stall=0, flush=0, new_pc=0, wd_timeout=0, stall_cnt_o=0. Deassert with stallreq_i=6'b000100 -> stall=6'b000111.
- Stall priority: stallreq_i=6'b001100 -> stall=6'b001111. stallreq_i=6'b000001 -> 6'b000001. Hold 10 cycles -> stall_cnt_o=10.
- Syscall: excepttype_i=0x08 with stallreq_i=6'b001000 in cycle t -> stall=0 in t. Flush=1, new_pc=0x40 in t+1 only (FLUSH_CYCLES=1). Back to 0 in t+2.
- ERET/interrupt: excepttype_i=0x0e, cp0_epc_i=0x1234 -> new_pc=0x1234. Then 0x01 -> 0x20. Then 0x55 -> 0x40. With FLUSH_CYCLES=3, flush is high for 3 cycles and a second exception inside the window is ignored.
- Watchdog: WD_LIMIT=4, stallreq_i held 6'b000100 -> stall=000111 for 4 cycles, then flush=1, new_pc=0x80, wd_timeout=1 for one cycle. A single non-stalled cycle after 3 stalls -> no trip.
- Async reset mid-flush (FLUSH_CYCLES=4, rst asserted after 2 flush cycles) -> flush=0 immediately. After release, state=RUN and the next exception redirects normally.

Source files
------------

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control unit for the MIPS core.
// It builds the per-stage stall vector and decodes MEM-stage exceptions into
// a registered flush/redirect. A flush is held for FLUSH_CYCLES cycles. A
// watchdog forces a redirect to WD_VEC when a stall stays asserted too long.
// A saturating counter records how many cycles had any stall active.
`timescale 1ns/1ps

module pipe_ctrl_gen #(
  parameter int          STAGES       = 6,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] INT_VEC      = 32'h0000_0020,
  parameter logic [31:0] EXC_VEC      = 32'h0000_0040,
  parameter logic [31:0] WD_VEC       = 32'h0000_0080,
  parameter int          WD_LIMIT     = 255,
  parameter int          WD_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic [31:0]       cp0_epc_i,
  input  logic [31:0]       excepttype_i,
  output logic [STAGES-1:0] stall,
  output logic [31:0]       new_pc,
  output logic              flush,
  output logic              wd_timeout,
  output logic [31:0]       stall_cnt_o
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'((WD_LIMIT > 0) ? (WD_LIMIT - 1) : 0);
  localparam bit WD_EN = (WD_LIMIT > 0);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state, state_n;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_n;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_n;
  logic [31:0]       new_pc_n;
  logic              flush_n;
  logic              wd_timeout_n;
  logic [31:0]       stall_cnt_n;
  logic [STAGES-1:0] stall_raw;
  logic              stall_any;
  logic              exc_pending;
  logic              wd_trip;
  logic [31:0]       exc_target;

  assign exc_pending = (excepttype_i != 32'd0);

  // A stall request at stage k also holds every earlier stage, so each bit is
  // the OR of its own request and all requests above it.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    stall_raw = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc          = acc | stallreq_i[j];
      stall_raw[j] = acc;
    end
  end

  // Stalls only apply in RUN with no exception pending; exceptions win.
  always_comb begin
    stall = '0;
    if (!rst && state == RUN && !exc_pending) begin
      stall = stall_raw;
    end
  end

  assign stall_any = |stall;
  assign wd_trip   = WD_EN && stall_any && (wd_cnt == WD_TRIP);

  // Map the exception code to its handler; ERET returns to the EPC.
  always_comb begin
    case (excepttype_i)
      32'h0000_0001: exc_target = INT_VEC;
      32'h0000_0008,
      32'h0000_000a,
      32'h0000_000c,
      32'h0000_000d: exc_target = EXC_VEC;
      32'h0000_000e: exc_target = cp0_epc_i;
      default:       exc_target = EXC_VEC;
    endcase
  end

  // Next-state and next-output logic for the RUN/FLUSH controller.
  always_comb begin
    state_n      = state;
    flush_n      = flush;
    new_pc_n     = new_pc;
    flush_cnt_n  = flush_cnt;
    wd_cnt_n     = '0;
    wd_timeout_n = 1'b0;
    stall_cnt_n  = stall_cnt_o;

    if (stall_any && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_n = stall_cnt_o + 32'd1;
    end

    case (state)
      RUN: begin
        if (exc_pending) begin
          state_n     = FLUSH;
          flush_n     = 1'b1;
          new_pc_n    = exc_target;
          flush_cnt_n = FC_INIT;
        end else if (wd_trip) begin
          state_n      = FLUSH;
          flush_n      = 1'b1;
          new_pc_n     = WD_VEC;
          flush_cnt_n  = FC_INIT;
          wd_timeout_n = 1'b1;
        end else if (WD_EN && stall_any) begin
          wd_cnt_n = wd_cnt + WD_W'(1);
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_n  = RUN;
          flush_n  = 1'b0;
          new_pc_n = 32'd0;
        end else begin
          flush_cnt_n = flush_cnt - FC_W'(1);
        end
      end
      default: begin
        state_n  = RUN;
        flush_n  = 1'b0;
        new_pc_n = 32'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any flush in progress at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      flush       <= 1'b0;
      new_pc      <= 32'd0;
      flush_cnt   <= '0;
      wd_cnt      <= '0;
      wd_timeout  <= 1'b0;
      stall_cnt_o <= 32'd0;
    end else begin
      state       <= state_n;
      flush       <= flush_n;
      new_pc      <= new_pc_n;
      flush_cnt   <= flush_cnt_n;
      wd_cnt      <= wd_cnt_n;
      wd_timeout  <= wd_timeout_n;
      stall_cnt_o <= stall_cnt_n;
    end
  end

endmodule
